ez90_preg_freelist: RTL and testbench

// - Physical-register free-list controller for the eZ90 P7 rename stage.
// - Replaces the renamer's monotonic preg counter with a circular FIFO of free pregs.
// - Supplies one preg per cycle to rename and reclaims one preg per cycle from commit.
// - Re-initialises on flush, in step with the rename map returning to identity.

---
 rtl/ez90_preg_freelist.sv | 148 ++++++++++++++
 tb/tb_ez90_preg_freelist.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ez90_preg_freelist.sv
// Physical-register free list for rename: circular FIFO re-seeded with pregs NUM_ARCH..NUM_PREG-1 after rst/flush.
// Latency: a freed preg is visible at the head one cycle later at the earliest; outputs depend on registered state only.
// Backpressure: alloc_ready low while seeding or empty; a free into a full list is dropped and flagged. Option: EZ90_FREELIST_CHECK_EN.
module ez90_preg_freelist #(
    parameter int NUM_PREG = 128,
    parameter int NUM_ARCH = 32,
    parameter int PREG_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              free_valid,
    input  logic [PREG_W-1:0] free_preg,
    output logic [PREG_W:0]   free_count,
    output logic              init_done,
    output logic              err
);
    localparam int DEPTH = NUM_PREG - NUM_ARCH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0]     LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [PREG_W:0]   DEPTH_CNT  = (PREG_W + 1)'(DEPTH);
    localparam logic [PREG_W-1:0] FIRST_FREE = PREG_W'(NUM_ARCH);
    localparam logic [PREG_W-1:0] LAST_PREG  = PREG_W'(NUM_PREG - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [PREG_W:0]     count;
    logic [PREG_W-1:0]   init_idx;
    logic [PREG_W-1:0]   mem [DEPTH];

    logic                alloc_fire;
    logic                overflow;
    logic                free_reject;
    logic                free_accept;
    logic                err_set;
    logic                mem_we;
    logic [PREG_W-1:0]   mem_wdata;

    // DEPTH is not necessarily a power of two, so wrap on an explicit compare.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign init_done   = (state == S_RUN);
    assign alloc_ready = (state == S_RUN) && (count != '0);
    assign alloc_preg  = alloc_ready ? mem[head] : '0;
    assign free_count  = count;

    assign alloc_fire = alloc_ready && alloc_valid;
    assign overflow   = free_valid && (count == DEPTH_CNT) && !alloc_fire;

`ifdef EZ90_FREELIST_CHECK_EN
    localparam logic [PREG_W:0] NUM_PREG_CNT = (PREG_W + 1)'(NUM_PREG);

    logic [NUM_PREG-1:0] in_list;
    logic                bad_preg;
    logic                dup_preg;

    assign bad_preg    = ({1'b0, free_preg} >= NUM_PREG_CNT);
    assign dup_preg    = !bad_preg && in_list[free_preg];
    assign free_reject = overflow || (free_valid && (bad_preg || dup_preg));

    // Tracks which pregs currently sit in the FIFO; rebuilt by INIT after a flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            in_list <= '0;
        end else begin
            if (mem_we) begin
                in_list[mem_wdata] <= 1'b1;
            end
            if (alloc_fire) begin
                in_list[alloc_preg] <= 1'b0;
            end
        end
    end
`else
    assign free_reject = overflow;
`endif

    assign free_accept = (state == S_RUN) && !flush && free_valid && !free_reject;
    assign err_set     = (state == S_RUN) && !flush && free_valid && free_reject;

    assign mem_we    = !rst && !flush && ((state == S_INIT) || free_accept);
    assign mem_wdata = (state == S_INIT) ? init_idx : free_preg;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[tail] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            init_idx <= FIRST_FREE;
            err      <= 1'b0;
        end else if (flush) begin
            // Restart seeding in step with the rename map; err is sticky across flush.
            state    <= S_INIT;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            init_idx <= FIRST_FREE;
        end else begin
            case (state)
                S_INIT: begin
                    tail     <= next_idx(tail);
                    count    <= count + 1'b1;
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == LAST_PREG) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (alloc_fire) begin
                        head <= next_idx(head);
                    end
                    if (free_accept) begin
                        tail <= next_idx(tail);
                    end
                    case ({alloc_fire, free_accept})
                        2'b10:   count <= count - 1'b1;
                        2'b01:   count <= count + 1'b1;
                        default: count <= count;
                    endcase
                    if (err_set) begin
                        err <= 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ez90_preg_freelist.sv
// Self-checking bench for ez90_preg_freelist: directed scenarios plus randomized traffic against a queue-based model.
module tb_ez90_preg_freelist;
    localparam int NUM_PREG = 128;
    localparam int NUM_ARCH = 32;
    localparam int DEPTH    = NUM_PREG - NUM_ARCH;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       free_valid = 1'b0;
    logic [6:0] free_preg = 7'd0;
    logic       alloc_ready;
    logic [6:0] alloc_preg;
    logic [7:0] free_count;
    logic       init_done;
    logic       err;

    int tests = 0;
    int fails = 0;

    // Reference model: the free list is literally an ordered queue of pregs.
    logic [6:0] mq[$];
    bit         m_run;
    int         m_next;
    bit         m_err;

    ez90_preg_freelist dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_preg  (alloc_preg),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .free_count  (free_count),
        .init_done   (init_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<2000000", $time);
        $fatal(1);
    end

    function automatic bit m_ready();
        return m_run && (mq.size() > 0);
    endfunction

    function automatic logic [6:0] m_preg();
        return m_ready() ? mq[0] : 7'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0;
        free_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        mq.delete();
        m_run = 1'b0;
        m_next = NUM_ARCH;
        m_err = 1'b0;
        #1;
        rst = 1'b0;
    endtask

    task automatic tick(input bit a, input bit f, input logic [6:0] p, input bit fl);
        bit afire;
        bit reject;
        alloc_valid = a;
        free_valid = f;
        free_preg = p;
        flush = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_run = 1'b0;
            m_next = NUM_ARCH;
        end else if (!m_run) begin
            mq.push_back(7'(m_next));
            if (m_next == NUM_PREG - 1) m_run = 1'b1;
            m_next++;
        end else begin
            afire = a && (mq.size() > 0);
            reject = f && (mq.size() == DEPTH) && !afire;
`ifdef EZ90_FREELIST_CHECK_EN
            if (f) begin
                foreach (mq[i]) if (mq[i] == p) reject = 1'b1;
            end
`endif
            if (afire) void'(mq.pop_front());
            if (f && reject) m_err = 1'b1;
            else if (f) mq.push_back(p);
        end
        #1;
        alloc_valid = 1'b0;
        free_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (alloc_ready !== 1'b0 || alloc_preg !== 7'd0 || free_count !== 8'd0 ||
            init_done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset: ready=%b preg=%0d count=%0d done=%b err=%b required 0 0 0 0 0",
                     alloc_ready, alloc_preg, free_count, init_done, err);
        end
    endtask

    task automatic test_init();
        // alloc/free are driven throughout INIT and must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 1'b1, 7'(i), 1'b0);
            if (i == DEPTH - 2) begin
                tests++;
                if (init_done !== 1'b0 || alloc_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL init_early: done=%b ready=%b after 95 cycles, required 0 0", init_done, alloc_ready);
                end
            end
        end
        tests++;
        if (init_done !== 1'b1 || free_count !== 8'd96 || alloc_ready !== 1'b1 || alloc_preg !== 7'd32) begin
            fails++;
            $display("FAIL init_done: done=%b count=%0d ready=%b preg=%0d required 1 96 1 32",
                     init_done, free_count, alloc_ready, alloc_preg);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (alloc_ready !== 1'b1 || alloc_preg !== 7'(NUM_ARCH + i)) begin
                fails++;
                $display("FAIL drain[%0d]: ready=%b preg=%0d required 1 %0d", i, alloc_ready, alloc_preg, NUM_ARCH + i);
            end
            tick(1'b1, 1'b0, 7'd0, 1'b0);
        end
        tests++;
        if (alloc_ready !== 1'b0 || free_count !== 8'd0 || alloc_preg !== 7'd0) begin
            fails++;
            $display("FAIL drain_empty: ready=%b count=%0d preg=%0d required 0 0 0", alloc_ready, free_count, alloc_preg);
        end
    endtask

    task automatic test_wrap();
        // Empty list: alloc and free together, only the free lands.
        tick(1'b1, 1'b1, 7'd40, 1'b0);
        tests++;
        if (alloc_ready !== 1'b1 || alloc_preg !== 7'd40 || free_count !== 8'd1) begin
            fails++;
            $display("FAIL wrap_first: ready=%b preg=%0d count=%0d required 1 40 1", alloc_ready, alloc_preg, free_count);
        end
        tick(1'b0, 1'b1, 7'd41, 1'b0);
        tests++;
        if (free_count !== 8'd2 || alloc_preg !== 7'd40) begin
            fails++;
            $display("FAIL wrap_second: count=%0d preg=%0d required 2 40", free_count, alloc_preg);
        end
        tick(1'b1, 1'b0, 7'd0, 1'b0);
        tests++;
        if (alloc_preg !== 7'd41 || free_count !== 8'd1) begin
            fails++;
            $display("FAIL wrap_alloc41: preg=%0d count=%0d required 41 1", alloc_preg, free_count);
        end
        tick(1'b1, 1'b0, 7'd0, 1'b0);
        tests++;
        if (alloc_ready !== 1'b0 || free_count !== 8'd0) begin
            fails++;
            $display("FAIL wrap_empty: ready=%b count=%0d required 0 0", alloc_ready, free_count);
        end
    endtask

    task automatic test_simul();
        tick(1'b0, 1'b1, 7'd77, 1'b0);
        tests++;
        if (alloc_ready !== 1'b1 || alloc_preg !== 7'd77 || free_count !== 8'd1) begin
            fails++;
            $display("FAIL simul_head: ready=%b preg=%0d count=%0d required 1 77 1", alloc_ready, alloc_preg, free_count);
        end
        tick(1'b1, 1'b1, 7'd90, 1'b0);
        tests++;
        if (free_count !== 8'd1 || alloc_preg !== 7'd90) begin
            fails++;
            $display("FAIL simul_after: count=%0d preg=%0d required 1 90", free_count, alloc_preg);
        end
        tick(1'b1, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic test_flush();
        do_reset();
        run_init();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 7'd0, 1'b0);
        tick(1'b1, 1'b1, 7'd5, 1'b1);
        tests++;
        if (init_done !== 1'b0 || free_count !== 8'd0 || alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_state: done=%b count=%0d ready=%b required 0 0 0", init_done, free_count, alloc_ready);
        end
        run_init();
        tests++;
        if (init_done !== 1'b1 || alloc_preg !== 7'd32 || free_count !== 8'd96 || err !== 1'b0) begin
            fails++;
            $display("FAIL flush_reinit: done=%b preg=%0d count=%0d err=%b required 1 32 96 0",
                     init_done, alloc_preg, free_count, err);
        end
    endtask

    task automatic test_overflow();
        tick(1'b0, 1'b1, 7'd5, 1'b0);
        tests++;
        if (free_count !== 8'd96 || err !== 1'b1) begin
            fails++;
            $display("FAIL overflow: count=%0d err=%b required 96 1", free_count, err);
        end
        tick(1'b1, 1'b1, 7'd6, 1'b0);
        tests++;
        if (free_count !== 8'd96 || alloc_preg !== 7'd33) begin
            fails++;
            $display("FAIL full_alloc_free: count=%0d preg=%0d required 96 33", free_count, alloc_preg);
        end
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        run_init();
        tests++;
        if (err !== 1'b1 || free_count !== 8'd96) begin
            fails++;
            $display("FAIL err_sticky: err=%b count=%0d required 1 96", err, free_count);
        end
    endtask

    task automatic test_check();
        do_reset();
        run_init();
        tick(1'b1, 1'b0, 7'd0, 1'b0);
        tick(1'b0, 1'b1, 7'd50, 1'b0);
        tests++;
`ifdef EZ90_FREELIST_CHECK_EN
        if (err !== 1'b1 || free_count !== 8'd95) begin
            fails++;
            $display("FAIL dup_free: err=%b count=%0d required 1 95", err, free_count);
        end
`else
        if (err !== 1'b0 || free_count !== 8'd96) begin
            fails++;
            $display("FAIL dup_free: err=%b count=%0d required 0 96", err, free_count);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0] pool[$];
        bit a, f, fl;
        logic [6:0] p;
        int idx;
        do_reset();
        run_init();
        for (int c = 0; c < 3000; c++) begin
            a = ($urandom % 4) != 0;
            f = ($urandom % 3) != 0;
            fl = ($urandom % 400) == 0;
            if (pool.size() > 0 && ($urandom % 5) != 0) begin
                idx = $urandom_range(0, pool.size() - 1);
                p = pool[idx];
                if (f) pool.delete(idx);
            end else begin
                p = 7'($urandom_range(0, NUM_PREG - 1));
            end
            if (a && m_ready() && !fl) pool.push_back(m_preg());
            if (fl) pool.delete();
            tick(a, f, p, fl);
            tests++;
            if (alloc_ready !== m_ready() || alloc_preg !== m_preg() || free_count !== 8'(mq.size()) ||
                init_done !== m_run || err !== m_err) begin
                fails++;
                $display("FAIL random[%0d]: ready=%b preg=%0d count=%0d done=%b err=%b required %b %0d %0d %b %b",
                         c, alloc_ready, alloc_preg, free_count, init_done, err,
                         m_ready(), m_preg(), mq.size(), m_run, m_err);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_init();
        test_drain();
        test_wrap();
        test_simul();
        test_flush();
        test_overflow();
        test_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
